// File: rtl/piso.sv
// piso: parallel-in serial-out converter, emits DATA_OUT_WIDTH slices LSB-first.
// Define PISO_PREFETCH_BUF_EN to add a one-word input buffer and decouple in_ready from out_ready.
module piso #(
  parameter int unsigned DATA_IN_WIDTH  = 64,
  parameter int unsigned DATA_OUT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_IN_WIDTH-1:0]  data_in,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy
);

  localparam int unsigned NUM_SHIFTS = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int unsigned CNT_W      = $clog2(NUM_SHIFTS) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SHIFTS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  generate
    if (((DATA_IN_WIDTH % DATA_OUT_WIDTH) != 0) || (NUM_SHIFTS < 1)) begin : g_bad_cfg
      $error("piso: DATA_IN_WIDTH must be a nonzero integer multiple of DATA_OUT_WIDTH");
    end
  endgenerate

  logic [DATA_IN_WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     out_fire;
  logic                     sh_free;
  logic                     in_fire;

  assign out_valid = (cnt_q != CNT_ZERO);
  assign data_out  = sh_q[DATA_OUT_WIDTH-1:0];
  assign out_last  = (cnt_q == CNT_ONE);
  assign out_fire  = out_valid && out_ready;
  // Free once the last slice leaves, so the next word follows without a bubble.
  assign sh_free   = (cnt_q == CNT_ZERO) || ((cnt_q == CNT_ONE) && out_fire);
  assign in_fire   = in_valid && in_ready;

`ifdef PISO_PREFETCH_BUF_EN
  logic [DATA_IN_WIDTH-1:0] buf_q, buf_d;
  logic                     buf_valid_q, buf_valid_d;

  assign in_ready = !buf_valid_q;
  assign busy     = out_valid || buf_valid_q;

  // Next state: buffered word refills sh first; otherwise new word goes to sh or buffer.
  always_comb begin
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    if (out_fire) begin
      sh_d  = sh_q >> DATA_OUT_WIDTH;
      cnt_d = cnt_q - CNT_ONE;
    end
    if (sh_free && buf_valid_q) begin
      sh_d        = buf_q;
      cnt_d       = CNT_FULL;
      buf_valid_d = 1'b0;
    end else if (in_fire) begin
      if (sh_free) begin
        sh_d  = data_in;
        cnt_d = CNT_FULL;
      end else begin
        buf_d       = data_in;
        buf_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q        <= '0;
      cnt_q       <= CNT_ZERO;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end
`else
  assign in_ready = (cnt_q == CNT_ZERO) || ((cnt_q == CNT_ONE) && out_ready);
  assign busy     = out_valid;

  // Next state: a load overrides the concurrent final-slice shift.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (out_fire) begin
      sh_d  = sh_q >> DATA_OUT_WIDTH;
      cnt_d = cnt_q - CNT_ONE;
    end
    if (in_fire && sh_free) begin
      sh_d  = data_in;
      cnt_d = CNT_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= CNT_ZERO;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule
